// File: rtl/led_scan_bcd.sv
// ----------------------------------------------------------------------------
// led_scan_bcd
//
// Multiplexed seven-segment display driver. A binary value is captured on an
// accepted load strobe and converted to BCD by a sequential shift-add-3
// (double dabble) engine, one bit per clock, so no wide dividers are needed.
// The committed BCD digits are time-multiplexed onto DIGITS common-select
// lines. The driver supports a programmable dwell time per digit, optional
// leading-zero blanking, per-digit decimal points and an overflow dash
// display.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   data_in     in   binary value to display, sampled on an accepted load
//   dp_in       in   decimal-point enables (bit i = digit i), sampled with
//                    data_in
//   load        in   conversion request, accepted only while busy = 0
//   busy        out  conversion in progress
//   done        out  one-cycle pulse when a new value reaches the display
//   overflow    out  last committed value was >= 10^DIGITS
//   led_sel     out  one-hot digit select, active high, bit 0 = LS digit
//   led_numseg  out  segments, active high: bit0 = a .. bit6 = g, bit7 = dp
// ----------------------------------------------------------------------------
module led_scan_bcd #(
  parameter int DIGITS   = 8,
  parameter int DATA_W   = 27,
  parameter int SCAN_DIV = 32768,
  parameter int BLANK_LZ = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DIGITS-1:0] dp_in,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [DIGITS-1:0] led_sel,
  output logic [7:0]        led_numseg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PS_W  = $clog2(SCAN_DIV);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // Smallest value that no longer fits in DIGITS decimal digits.
  localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

  // Double-dabble correction: every nibble >= 5 gets +3 so that the
  // following left shift carries correctly into the next decade. Nibbles
  // above the displayable range may hold garbage for overflowing values;
  // the 4-bit wrap is harmless because such values are shown as dashes.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    logic [3:0]       nib;
    r = b;
    for (int k = 0; k < DIGITS; k++) begin
      nib = b[k*4 +: 4];
      if (nib >= 4'd5) begin
        r[k*4 +: 4] = nib + 4'd3;
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Converter state
  state_t             state_q, state_d;
  logic [DATA_W-1:0]  sr_q, sr_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGITS-1:0]  dp_hold_q, dp_hold_d;
  logic               ovf_pend_q, ovf_pend_d;

  // Committed display state
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic [DIGITS-1:0]  disp_dp_q, disp_dp_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;

  // Scanner state
  logic [PS_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0]  led_sel_q, led_sel_d;
  logic [7:0]         led_numseg_q, led_numseg_d;

  // Scratch signals for the converter and the digit decoder
  logic [BCD_W+DATA_W-1:0] shift_cat;
  logic [BCD_W-1:0]        upper;
  logic                    blank;
  logic [6:0]              seg;

  // --------------------------------------------------------------------------
  // Converter: next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    dp_hold_d  = dp_hold_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    disp_dp_d  = disp_dp_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    // The BCD bit shifted out of the top is discarded; overflow is decided
    // from the captured binary value instead.
    shift_cat  = {bcd_adjust(bcd_q), sr_q} << 1;

    case (state_q)
      IDLE: begin
        if (load) begin
          sr_d       = data_in;
          dp_hold_d  = dp_in;
          ovf_pend_d = (64'(data_in) >= OVF_LIMIT);
          bcd_d      = '0;
          cnt_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = shift_cat[BCD_W+DATA_W-1:DATA_W];
        sr_d  = shift_cat[DATA_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        disp_d     = bcd_q;
        disp_dp_d  = dp_hold_q;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Scanner: prescaler, digit index and registered pin drivers
  // --------------------------------------------------------------------------
  always_comb begin
    presc_d = presc_q + PS_W'(1);
    idx_d   = idx_q;
    if (presc_q == PS_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    // Digits at and above idx: the low nibble is the current digit, and the
    // whole slice being zero means this digit is a leading zero.
    upper = disp_q >> {idx_q, 2'b00};
    blank = (BLANK_LZ != 0) && (idx_q != '0) && (upper == '0);

    if (overflow_q) begin
      seg = 7'h40;
    end else if (blank) begin
      seg = 7'h00;
    end else begin
      seg = seg7(upper[3:0]);
    end

    led_sel_d    = DIGITS'(1) << idx_q;
    led_numseg_d = {disp_dp_q[idx_q], seg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      dp_hold_q    <= '0;
      ovf_pend_q   <= 1'b0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
      presc_q      <= '0;
      idx_q        <= '0;
      led_sel_q    <= '0;
      led_numseg_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      dp_hold_q    <= dp_hold_d;
      ovf_pend_q   <= ovf_pend_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      led_sel_q    <= led_sel_d;
      led_numseg_q <= led_numseg_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign led_sel    = led_sel_q;
  assign led_numseg = led_numseg_q;

endmodule

// File: doc/led_scan_bcd.md
# led_scan_bcd

Parametrised multiplexed seven-segment display driver for the DDS front panel. It accepts a binary value on a load strobe and converts it to BCD with a sequential shift-add-3 engine, so no wide dividers are used. It then time-multiplexes DIGITS common-select lines with programmable scan rate, leading-zero blanking, per-digit decimal points and overflow indication. It sits between the DDS control/frequency registers and the board's segment/select pins.

## Interface
- DIGITS, 8: number of displayed digits (1..8).
- DATA_W, 27: width of binary input; must satisfy 2^DATA_W > 10^DIGITS - 1 (non-overflowing values must fit).
- SCAN_DIV, 32768: clk cycles each digit is held (>= 2).
- BLANK_LZ, 1: 1 = blank leading zeros, 0 = show all digits.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  DATA_W  binary value to display; sampled on accepted load.
- dp_in  in  DIGITS  decimal-point enables, bit i = digit i; sampled with data_in.
- load  in  1  request conversion; accepted only when busy = 0.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when new value is committed to display.
- overflow  out  1  last committed value was >= 10^DIGITS.
- led_sel  out  DIGITS  one-hot digit select, active high, bit 0 = least significant digit.
- led_numseg  out  8  segments, active high: bit0 = a … bit6 = g, bit7 = dp.

## Operation
- Converter FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on load = 1, capture data_in into shift reg and dp_in into dp_hold. Set ovf_pend = (data_in >= 10^DIGITS). Clear BCD accumulator (4*DIGITS bits), clear bit counter, go SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift {BCD, shift reg} left by one. After DATA_W shifts, go COMMIT. BCD bits above 4*DIGITS are discarded; overflow is decided solely by ovf_pend.
  - COMMIT: copy BCD to disp, dp_hold to disp_dp, ovf_pend to overflow. Pulse done; return to IDLE.
- load while busy = 1 is ignored (no queueing).
- Scan: the prescaler counts 0..SCAN_DIV-1 continuously. At the terminal count it wraps to 0 and digit index idx advances, with DIGITS-1 wrapping to 0.
- Per-digit segment code: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Nibbles 10..15 cannot occur.
- Blanking: with BLANK_LZ = 1, digit i > 0 is blanked (segments a..g = 0) when disp nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked.
- Overflow: when overflow = 1, every digit shows dash (0x40) regardless of disp, and blanking does not apply.
- bit7 of led_numseg = disp_dp[idx] in all cases, including blanked and dash digits.

## Timing
- Reset (async, immediate):
  - busy = 0, done = 0, overflow = 0.
  - disp = all zero, disp_dp = 0.
  - prescaler = 0, idx = 0.
  - led_sel = 0, led_numseg = 0x00.
  - FSM = IDLE.
- led_sel and led_numseg are registered from idx/disp and lag idx by one cycle. The first clock after reset release drives led_sel = 1 and led_numseg = 0x3F.
- Conversion latency:
  - load sampled at edge E0; busy = 1 from E0.
  - SHIFT occupies edges E1..E_DATA_W.
  - COMMIT at edge E(DATA_W+1): disp updated, done = 1 for that cycle, busy = 0.
  - busy is high for DATA_W + 1 cycles. A new load is accepted at the edge following COMMIT.
- Display refresh: the new disp is visible on led_numseg one cycle after COMMIT, for whichever digit is currently selected. Scanning is never stalled or reset by a conversion.
- Digit dwell: each digit is held exactly SCAN_DIV cycles; a full frame is DIGITS*SCAN_DIV cycles.
- Reset asserted mid-conversion aborts it: no done pulse, and disp stays cleared.

## Test plan
Bench uses DIGITS = 8, DATA_W = 27, SCAN_DIV = 4, BLANK_LZ = 1.
1. Reset check: hold rst_n low, then release. Required: all outputs at reset values; first edge gives led_sel = 0x01, led_numseg = 0x3F; led_sel steps 0x01→0x02→…→0x80→0x01 every 4 cycles.
2. Load 12345678 with dp_in = 0x10. Required: busy high exactly 28 cycles, done pulse on the cycle busy falls. Digits 0..7 then read 7F, 07, 7D, 6D, 66, 4F, 5B, 06; digit 4 has bit7 = 1 (0xE6).
3. Load 42 with dp_in = 0. Required: digit0 = 0x5B, digit1 = 0x66, digits 2..7 = 0x00. Then load 0: only digit0 = 0x3F, all others 0x00.
4. Load 100000000. Required: overflow = 1 and all digits 0x40. Then load 99999999: overflow = 0 and all digits 0x6F.
5. Pulse load at cycle 5 of an active conversion with a different value. Required: the pulse is ignored, busy timing is unchanged, and the first value is displayed.
6. Assert rst_n low at SHIFT cycle 10, then release. Required: busy = 0, no done pulse, display shows digit0 = 0x3F with the others blank, and the next load completes normally in 28 cycles.
